row_buf_ring: RTL

Parametrised N-deep ring of scanline row buffers between the pixel mixer (writer) and HDMI video output (reader) in the PPU. It generalises the two-buffer ping-pong row RAM to NBUF buffers with configurable width and row length. It adds an explicit write-commit/ready handshake, queued lines, occupancy reporting, and defined repeat behaviour when the reader swaps before a new line is committed.

---
 rtl/row_buf_ring.sv | 113 +++++++++++
 1 files changed

// File: rtl/row_buf_ring.sv
// NBUF-deep ring of scanline row buffers with commit/ready handshake and repeat on underflow.
// Optional: define ROWBUF_BLANK_ON_REPEAT_EN to blank rd_data for a repeated line.
module row_buf_ring #(
  parameter int DATA_W  = 10,
  parameter int ROW_LEN = 320,
  parameter int ADDR_W  = 9,
  parameter int NBUF    = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rowram_swap,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         wr_commit,
  output logic                         wr_ready,
  output logic                         rd_repeat,
  output logic [$clog2(NBUF+1)-1:0]    fill_count
);

  localparam int IDX_W = $clog2(NBUF);
  localparam int CNT_W = $clog2(NBUF + 1);
  localparam int SUM_W = IDX_W + 2;
  localparam int DEPTH = NBUF << ADDR_W;

  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NBUF - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NBUF - 1);
  localparam logic [ADDR_W:0]   ROW_END  = (ADDR_W + 1)'(ROW_LEN);
  localparam logic [SUM_W-1:0]  SUM_NBUF = SUM_W'(NBUF);

  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_repeat_q, rd_repeat_d;

  logic [SUM_W-1:0]  wr_sum;
  logic [IDX_W-1:0]  wr_idx;
  logic              swap_acc, repeat_hit, commit_acc, wr_ok, blank;
  logic [DATA_W-1:0] mem_rd_word;

  logic [DATA_W-1:0] mem [DEPTH];

  assign wr_ready   = (cnt_q < CNT_FULL);
  assign fill_count = cnt_q;
  assign rd_data    = rd_data_q;
  assign rd_repeat  = rd_repeat_q;

  // Write slot sits just past the queued lines; sum is < 2*NBUF so one subtraction wraps it.
  assign wr_sum = SUM_W'(rd_idx_q) + SUM_W'(cnt_q) + SUM_W'(1);
  assign wr_idx = (wr_sum >= SUM_NBUF) ? IDX_W'(wr_sum - SUM_NBUF) : IDX_W'(wr_sum);
  assign wr_ok  = wr_en && wr_ready && ({1'b0, wr_addr} < ROW_END);

  assign mem_rd_word = mem[{rd_idx_q, rd_addr}];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[{wr_idx, wr_addr}] <= wr_data;
  end

`ifdef ROWBUF_BLANK_ON_REPEAT_EN
  logic blank_q, blank_d;

  always_comb begin
    blank_d = blank_q;
    if (repeat_hit)    blank_d = 1'b1;
    else if (swap_acc) blank_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_q <= 1'b0;
    else        blank_q <= blank_d;
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

  // Swap and commit both see the pre-cycle count; no bypass between them.
  always_comb begin
    swap_acc    = rowram_swap && (cnt_q != '0);
    repeat_hit  = rowram_swap && (cnt_q == '0);
    commit_acc  = wr_commit && wr_ready;

    cnt_d = cnt_q;
    if (commit_acc && !swap_acc)      cnt_d = cnt_q + 1'b1;
    else if (!commit_acc && swap_acc) cnt_d = cnt_q - 1'b1;

    rd_idx_d = rd_idx_q;
    if (swap_acc) rd_idx_d = (rd_idx_q == IDX_LAST) ? '0 : rd_idx_q + 1'b1;

    rd_repeat_d = repeat_hit;

    rd_data_d = '0;
    if (({1'b0, rd_addr} < ROW_END) && !blank) rd_data_d = mem_rd_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx_q    <= '0;
      cnt_q       <= '0;
      rd_data_q   <= '0;
      rd_repeat_q <= 1'b0;
    end else begin
      rd_idx_q    <= rd_idx_d;
      cnt_q       <= cnt_d;
      rd_data_q   <= rd_data_d;
      rd_repeat_q <= rd_repeat_d;
    end
  end

endmodule
